// File: rtl/chacha_pkg.sv
// Shared defaults and state encoding for the ChaCha ciphertext output path.
package chacha_pkg;

    localparam int DATA_SIZE_DEF    = 8;
    localparam int NUM_MATRICES_DEF = 1;
    localparam int NO_REG_DEF       = 64 * NUM_MATRICES_DEF;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/cipher_text_serializer.sv
// Latches a parallel ciphertext frame and streams it out one byte per
// valid/ready handshake, with a done pulse when the frame completes.
module cipher_text_serializer
    import chacha_pkg::*;
#(
    parameter int DATA_SIZE    = DATA_SIZE_DEF,
    parameter int NUM_MATRICES = NUM_MATRICES_DEF,
    parameter int NO_REG       = 64 * NUM_MATRICES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NO_REG*DATA_SIZE-1:0] block_in,
    input  logic [$clog2(NO_REG):0]     block_len,
    input  logic                        block_valid,
    output logic                        block_ready,
    output logic [DATA_SIZE-1:0]        char_out_CT,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        done
);

    localparam int LEN_W  = $clog2(NO_REG) + 1;
    localparam int ADDR_W = LEN_W - 1;

    state_t                state_r;
    logic [ADDR_W-1:0]     rd_addr_r;
    logic [LEN_W-1:0]      len_r;
    logic [DATA_SIZE-1:0]  storage_r [NO_REG];
    logic [DATA_SIZE-1:0]  char_r;
    logic                  ready_r;
    logic                  valid_r;
    logic                  last_r;
    logic                  done_r;

    logic [LEN_W-1:0]      eff_len_s;
    logic [ADDR_W-1:0]     next_addr_s;
    logic                  at_last_s;
    logic                  next_is_last_s;

    // Length clamp and read-pointer lookahead for the FSM.
    always_comb begin
        eff_len_s      = block_len;
        next_addr_s    = rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        at_last_s      = ({1'b0, rd_addr_r} == (len_r - LEN_W'(1)));
        next_is_last_s = ({1'b0, next_addr_s} == (len_r - LEN_W'(1)));
        if (block_len > LEN_W'(NO_REG)) begin
            eff_len_s = LEN_W'(NO_REG);
        end else begin
            eff_len_s = block_len;
        end
    end

    // Frame capture, byte sequencing and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            rd_addr_r <= {ADDR_W{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            char_r    <= {DATA_SIZE{1'b0}};
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            done_r    <= 1'b0;
            for (int i = 0; i < NO_REG; i++) begin
                storage_r[i] <= {DATA_SIZE{1'b0}};
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (block_valid) begin
                        for (int i = 0; i < NO_REG; i++) begin
                            storage_r[i] <= block_in[i*DATA_SIZE +: DATA_SIZE];
                        end
                        len_r     <= eff_len_s;
                        rd_addr_r <= {ADDR_W{1'b0}};
                        // An empty frame completes immediately without streaming.
                        if (eff_len_s != {LEN_W{1'b0}}) begin
                            state_r <= STREAM;
                            ready_r <= 1'b0;
                            valid_r <= 1'b1;
                            char_r  <= block_in[DATA_SIZE-1:0];
                            last_r  <= (eff_len_s == LEN_W'(1));
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (at_last_s) begin
                            state_r <= IDLE;
                            ready_r <= 1'b1;
                            valid_r <= 1'b0;
                            char_r  <= {DATA_SIZE{1'b0}};
                            last_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            rd_addr_r <= next_addr_s;
                            char_r    <= storage_r[next_addr_s];
                            last_r    <= next_is_last_s;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                    char_r  <= {DATA_SIZE{1'b0}};
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign block_ready = ready_r;
    assign char_out_CT = char_r;
    assign out_valid   = valid_r;
    assign out_last    = last_r;
    assign done        = done_r;

endmodule

// File: tb/tb_cipher_text_serializer.sv
// Directed bench for cipher_text_serializer with a byte scoreboard and monitor.
module tb_cipher_text_serializer;

    localparam int NR = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR*8-1:0] block_in = '0;
    logic [6:0]      block_len = 7'd0;
    logic            block_valid = 1'b0;
    logic            block_ready;
    logic [7:0]      char_out_CT;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            out_last;
    logic            done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    logic [8:0] sb_q[$];

    cipher_text_serializer dut (
        .clk(clk), .rst(rst), .block_in(block_in), .block_len(block_len),
        .block_valid(block_valid), .block_ready(block_ready),
        .char_out_CT(char_out_CT), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a frame of bytes base+i, wait for acceptance, push expected bytes.
    task automatic accept_frame(input logic [7:0] base, input int len, input bit keep,
                                output logic done_at_acc);
        int lim;
        int k;
        lim = (len > NR) ? NR : len;
        for (int i = 0; i < NR; i++) block_in[i*8 +: 8] = base + 8'(i);
        block_len = 7'(len);
        block_valid = 1'b1;
        done_at_acc = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (block_ready) break;
        end
        chk("accept_timeout", 32'(k < 100), 32'd1);
        done_at_acc = done;
        for (int i = 0; i < lim; i++) sb_q.push_back({(i == lim - 1), base + 8'(i)});
        @(posedge clk); #1;
        if (!keep) block_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        for (n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_timeout", 32'(n <= 300), 32'd1);
    endtask

    // Monitor: scoreboard pops, stall stability and idle-zero checks.
    initial begin
        logic       stall_p;
        logic [8:0] held;
        logic [8:0] exp;
        stall_p = 1'b0;
        held = 9'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (out_valid) begin
                    if (stall_p) chk("stall_hold", 32'({out_last, char_out_CT}), 32'(held));
                    if (out_ready) begin
                        chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                        if (sb_q.size() > 0) begin
                            exp = sb_q.pop_front();
                            chk("sb_byte", 32'({out_last, char_out_CT}), 32'(exp));
                        end
                        xfer_cnt++;
                    end
                end else begin
                    chk("idle_zero", 32'({out_last, char_out_CT}), 32'd0);
                end
                if (done) done_cnt++;
                stall_p = out_valid && !out_ready;
                held = {out_last, char_out_CT};
            end else begin
                stall_p = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int x0;
        int dc;
        int k;
        logic d;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(block_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_char", 32'(char_out_CT), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        @(posedge clk); #1;

        // Full frame, bytes 0x00..0x3F.
        accept_frame(8'h00, 64, 1'b0, d);
        chk("lat1_valid", 32'(out_valid), 32'd1);
        chk("lat1_byte", 32'(char_out_CT), 32'd0);
        wait_done(n);
        chk("full_done_cycle", 32'(n), 32'd65);
        chk("full_q_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        @(posedge clk); #1;

        // Partial frame of five bytes.
        accept_frame(8'hA0, 5, 1'b0, d);
        wait_done(n);
        chk("partial_done_cycle", 32'(n), 32'd6);
        chk("partial_ready", 32'(block_ready), 32'd1);
        chk("partial_q_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;

        // Backpressure with out_ready pattern 1,0,0,1.
        accept_frame(8'h10, 10, 1'b0, d);
        for (k = 0; k < 200; k++) begin
            out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1;
        end
        chk("bp_timeout", 32'(k < 200), 32'd1);
        chk("bp_q_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Zero length: immediate done, nothing streamed.
        accept_frame(8'h55, 0, 1'b0, d);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_valid", 32'(out_valid), 32'd0);
        chk("len0_ready", 32'(block_ready), 32'd1);
        @(posedge clk); #1;
        chk("len0_done_drop", 32'(done), 32'd0);

        // Oversized length clamps to 64 bytes.
        accept_frame(8'h40, 100, 1'b0, d);
        wait_done(n);
        chk("len100_done_cycle", 32'(n), 32'd65);
        chk("len100_q_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;

        // Reset after ten bytes.
        accept_frame(8'h80, 64, 1'b0, d);
        x0 = xfer_cnt;
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            if (xfer_cnt - x0 >= 10) break;
        end
        chk("rst10_timeout", 32'(k < 200), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_char", 32'(char_out_CT), 32'd0);
        sb_q.delete();
        dc = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'(dc));
        chk("midrst_ready", 32'(block_ready), 32'd1);
        @(posedge clk); #1;
        accept_frame(8'hC0, 64, 1'b0, d);
        wait_done(n);
        chk("after_rst_done_cycle", 32'(n), 32'd65);
        chk("after_rst_q_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;

        // Back-to-back frames with block_valid held high.
        accept_frame(8'h20, 4, 1'b1, d);
        accept_frame(8'h30, 3, 1'b0, d);
        chk("b2b_accept_in_done", 32'(d), 32'd1);
        wait_done(n);
        chk("b2b_done_cycle", 32'(n), 32'd4);
        chk("b2b_q_empty", 32'(sb_q.size()), 32'd0);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cipher_text_serializer.md
CIPHER_TEXT_SERIALIZER -- requirements
Module: cipher_text_serializer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, byte width in bits.
REQ-002 SHALL have parameter NUM_MATRICES, default 1, number of 64-byte keystream blocks per frame.
REQ-003 SHALL have parameter NO_REG, default 64*NUM_MATRICES, bytes per frame.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port block_in, input, NO_REG x DATA_SIZE, parallel ciphertext frame from the XOR stage.
REQ-007 SHALL have port block_len, input, $clog2(NO_REG)+1, number of valid bytes in block_in, starting at index 0.
REQ-008 SHALL have port block_valid, input, 1, meaning block_in and block_len are valid.
REQ-009 SHALL have port block_ready, output, 1, meaning a frame is accepted this cycle.
REQ-010 SHALL have port char_out_CT, output, DATA_SIZE, the current serialized byte.
REQ-011 SHALL have port out_valid, output, 1, meaning char_out_CT is valid.
REQ-012 SHALL have port out_ready, input, 1, consumer backpressure.
REQ-013 SHALL have port out_last, output, 1, marking the final byte of a frame.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse when a frame completes.

Function
REQ-015 SHALL implement states IDLE and STREAM.
REQ-016 SHALL drive block_ready=1 only in IDLE.
REQ-017 SHALL accept a frame on a rising edge with block_valid&&block_ready, then latch all NO_REG bytes into internal storage and latch the effective length L.
REQ-018 SHALL compute L = min(block_len, NO_REG); values above NO_REG SHALL be clamped to NO_REG.
REQ-019 SHALL, on accept with L>0, enter STREAM with rd_addr=0; out_valid SHALL rise the cycle after accept, giving latency 1.
REQ-020 SHALL, on accept with L=0, stay in IDLE, emit no bytes, and pulse done the next cycle.
REQ-021 SHALL, in STREAM, drive out_valid=1 and char_out_CT=storage[rd_addr].
REQ-022 SHALL drive out_last=1 exactly when rd_addr==L-1 in STREAM.
REQ-023 SHALL treat a byte as transferred on a rising edge with out_valid&&out_ready; rd_addr SHALL then increment by 1.
REQ-024 SHALL hold char_out_CT, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on transfer of the last byte, return to IDLE and pulse done for one cycle; block_ready SHALL be 1 in that same cycle, allowing back-to-back frames with one bubble cycle.
REQ-026 SHALL ignore block_valid while in STREAM; storage SHALL NOT change mid-frame.
REQ-027 SHALL never let rd_addr exceed L-1; no wrap-around SHALL occur within a frame.
REQ-028 SHALL drive char_out_CT to 0 and out_last to 0 whenever out_valid=0.

Reset
REQ-029 SHALL, on rst=0 and asynchronously, force state=IDLE, rd_addr=0, L=0, out_valid=0, out_last=0, done=0, char_out_CT=0, and clear storage to 0.
REQ-030 SHALL drop out_valid immediately on a reset asserted mid-frame; the partial frame SHALL be discarded and no done pulse SHALL be produced.
REQ-031 SHALL drive block_ready=1 in the first cycle after rst deasserts.

Structure
REQ-032 SHALL place DATA_SIZE, NUM_MATRICES and NO_REG defaults, plus the state enum (IDLE, STREAM), in shared package chacha_pkg.
REQ-033 SHALL be a single module with no sub-modules; the storage array, counter and FSM are all local.

Verification
REQ-034 SHALL cover a full frame: block_in[i]=i, block_len=64, out_ready=1 -> bytes 0x00..0x3F on 64 consecutive cycles, out_last on 0x3F, done one cycle later.
REQ-035 SHALL cover a partial frame: block_len=5, bytes 0xA0..0xA4 -> exactly 5 bytes, out_last on 0xA4, then return to IDLE.
REQ-036 SHALL cover backpressure: out_ready toggled 1,0,0,1 during a frame -> each byte held stable while stalled, no byte dropped or duplicated.
REQ-037 SHALL cover edge lengths: block_len=0 -> no out_valid and a done pulse; block_len=100 -> exactly 64 bytes.
REQ-038 SHALL cover reset mid-frame: rst=0 after 10 bytes -> out_valid=0 at once and no done; a new frame afterwards streams from index 0.
REQ-039 SHALL cover back-to-back frames: block_valid held high with two frames -> second frame accepted in the done cycle, and its bytes do not corrupt the first.
